// File: rtl/instmem_loader.sv
// ---------------------------------------------------------------------------
// instmem_loader
//   Parametrised instruction memory with a post-reset clear sweep, a
//   registered fetch port and a handshake-driven program load engine.
//
//   After reset the memory is swept to CLEAR_WORD, one word per cycle for
//   DEPTH cycles. In IDLE, fetches return a result one cycle after the
//   request. A load streams words from a base address with auto-increment.
//   Fetches are only accepted in IDLE.
//
// Ports:
//   i_clk           clock, all state on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_fetch_req     fetch request, sampled when o_fetch_ready=1
//   i_fetch_addr    word address of the fetch
//   o_fetch_ready   high only in IDLE
//   o_fetch_valid   one-cycle pulse, fetch result present
//   o_fetch_data    registered fetch result (holds while o_fetch_valid=0)
//   o_fetch_err     qualifies o_fetch_valid: address >= DEPTH
//   i_load_start    begin a load, honoured only in IDLE
//   i_load_base     first load address, captured with i_load_start
//   i_load_valid    load word present
//   i_load_data     load word
//   i_load_last     final word of the load, qualified by i_load_valid
//   o_load_ready    high only in LOAD
//   o_load_done     one-cycle pulse after the last word is written
//   o_load_err      sticky overflow/bad-base flag
//   o_busy          high in CLEAR or LOAD
// ---------------------------------------------------------------------------
module instmem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter logic [DATA_W-1:0] CLEAR_WORD = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_ready,
  output logic              o_fetch_valid,
  output logic [DATA_W-1:0] o_fetch_data,
  output logic              o_fetch_err,
  input  logic              i_load_start,
  input  logic [ADDR_W-1:0] i_load_base,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic              o_busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;
  logic              r_load_done;
  logic              w_load_done_next;
  logic              r_load_err;
  logic              w_load_err_next;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_fetch_fire;
  logic              w_fetch_in_range;
  logic              w_base_in_range;
  logic              w_ptr_at_end;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_fetch_valid;
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_fetch_err;

  assign w_fetch_in_range = ({1'b0, i_fetch_addr} < DEPTH_EXT);
  assign w_base_in_range  = ({1'b0, i_load_base} < DEPTH_EXT);
  assign w_ptr_at_end     = (r_ptr == LAST_PTR);

  // State, pointer and sticky load flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_CLEAR;
      r_ptr       <= '0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_load_done <= w_load_done_next;
      r_load_err  <= w_load_err_next;
    end
  end

  // Next-state logic and memory write control. The pointer is left alone
  // when leaving LOAD so it never steps past DEPTH-1.
  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_load_done_next = 1'b0;
    w_load_err_next  = r_load_err;
    w_mem_we         = 1'b0;
    w_mem_wdata      = i_load_data;
    w_fetch_fire     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = CLEAR_WORD;
        if (w_ptr_at_end) begin
          w_state_next = ST_IDLE;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next = r_ptr + PTR_ONE;
        end
      end
      ST_IDLE: begin
        w_fetch_fire = i_fetch_req;
        if (i_load_start) begin
          if (w_base_in_range) begin
            w_state_next    = ST_LOAD;
            w_ptr_next      = i_load_base;
            w_load_err_next = 1'b0;
          end else begin
            w_load_err_next = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (i_load_valid) begin
          w_mem_we = 1'b1;
          if (i_load_last) begin
            w_state_next     = ST_IDLE;
            w_load_done_next = 1'b1;
          end else if (w_ptr_at_end) begin
            w_state_next    = ST_IDLE;
            w_load_err_next = 1'b1;
          end else begin
            w_ptr_next = r_ptr + PTR_ONE;
          end
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
        w_ptr_next   = '0;
      end
    endcase
  end

  // Storage array: no reset, the clear sweep initialises it.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[r_ptr[IDX_W-1:0]] <= w_mem_wdata;
    end
  end

  // Registered fetch port. Data holds between results; an out-of-range
  // address returns zero with the error flag raised.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
      r_fetch_err   <= 1'b0;
    end else if (w_fetch_fire) begin
      r_fetch_valid <= 1'b1;
      if (w_fetch_in_range) begin
        r_fetch_data <= r_mem[i_fetch_addr[IDX_W-1:0]];
        r_fetch_err  <= 1'b0;
      end else begin
        r_fetch_data <= '0;
        r_fetch_err  <= 1'b1;
      end
    end else begin
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end
  end

  assign o_fetch_ready = (r_state == ST_IDLE);
  assign o_load_ready  = (r_state == ST_LOAD);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_data  = r_fetch_data;
  assign o_fetch_err   = r_fetch_err;
  assign o_load_done   = r_load_done;
  assign o_load_err    = r_load_err;

endmodule

// File: tb/tb_instmem_loader.sv
// ---------------------------------------------------------------------------
// tb_instmem_loader
//   Directed bench for instmem_loader with DATA_W=32, ADDR_W=16, DEPTH=256.
//   Inputs are driven 1ns after the rising edge and outputs are sampled at
//   the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_instmem_loader;

  logic        clk;
  logic        rstN;
  logic        fetchReq;
  logic [15:0] fetchAddr;
  logic        fetchReady;
  logic        fetchValid;
  logic [31:0] fetchData;
  logic        fetchErr;
  logic        loadStart;
  logic [15:0] loadBase;
  logic        loadValid;
  logic [31:0] loadData;
  logic        loadLast;
  logic        loadReady;
  logic        loadDone;
  logic        loadErr;
  logic        busy;

  int nVectors;
  int nMiscompares;
  int sweepCycles;
  int donePulses;

  instmem_loader #(
    .DATA_W(32),
    .ADDR_W(16),
    .DEPTH(256),
    .CLEAR_WORD(32'h0000_0000)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_fetch_req(fetchReq),
    .i_fetch_addr(fetchAddr),
    .o_fetch_ready(fetchReady),
    .o_fetch_valid(fetchValid),
    .o_fetch_data(fetchData),
    .o_fetch_err(fetchErr),
    .i_load_start(loadStart),
    .i_load_base(loadBase),
    .i_load_valid(loadValid),
    .i_load_data(loadData),
    .i_load_last(loadLast),
    .o_load_ready(loadReady),
    .o_load_done(loadDone),
    .o_load_err(loadErr),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock step: return 1ns after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Single fetch: request one cycle, check the registered result.
  task automatic doFetch(input string tag, input logic [15:0] addr,
                         input logic [31:0] expData, input logic expErr);
    fetchReq  = 1'b1;
    fetchAddr = addr;
    applyStimulus();
    fetchReq = 1'b0;
    checkOutput({tag, "_valid"}, 64'(fetchValid), 64'd1);
    checkOutput({tag, "_data"}, 64'(fetchData), 64'(expData));
    checkOutput({tag, "_err"}, 64'(fetchErr), 64'(expErr));
  endtask

  // Count cycles until busy drops, bounded well past DEPTH.
  task automatic measureSweep(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 300) begin
      applyStimulus();
      cycles++;
    end
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    donePulses   = 0;
    rstN      = 1'b1;
    fetchReq  = 1'b0;
    fetchAddr = '0;
    loadStart = 1'b0;
    loadBase  = '0;
    loadValid = 1'b0;
    loadData  = '0;
    loadLast  = 1'b0;

    // Reset and sweep.
    #2 rstN = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_busy", 64'(busy), 64'd1);
    checkOutput("rst_fetch_ready", 64'(fetchReady), 64'd0);
    checkOutput("rst_load_ready", 64'(loadReady), 64'd0);
    checkOutput("rst_fetch_valid", 64'(fetchValid), 64'd0);
    checkOutput("rst_fetch_data", 64'(fetchData), 64'd0);
    checkOutput("rst_load_err", 64'(loadErr), 64'd0);
    checkOutput("rst_load_done", 64'(loadDone), 64'd0);
    rstN = 1'b1;
    fetchReq  = 1'b1;
    loadStart = 1'b1;
    loadBase  = 16'd4;
    measureSweep(sweepCycles);
    checkOutput("sweep_cycles", 64'(sweepCycles), 64'd256);
    checkOutput("sweep_fetch_ready", 64'(fetchReady), 64'd1);
    checkOutput("sweep_ignored_fetch", 64'(fetchValid), 64'd0);
    fetchReq  = 1'b0;
    loadStart = 1'b0;
    doFetch("clr0", 16'd0, 32'h0, 1'b0);
    doFetch("clr128", 16'd128, 32'h0, 1'b0);
    doFetch("clr255", 16'd255, 32'h0, 1'b0);

    // Load three words from base 4.
    loadStart = 1'b1;
    loadBase  = 16'd4;
    applyStimulus();
    loadStart = 1'b0;
    checkOutput("ld4_ready", 64'(loadReady), 64'd1);
    checkOutput("ld4_busy", 64'(busy), 64'd1);
    fetchReq  = 1'b1;
    fetchAddr = 16'd4;
    loadValid = 1'b1;
    loadData  = 32'h1111_1111;
    applyStimulus();
    checkOutput("ld4_fetch_blocked", 64'(fetchValid), 64'd0);
    fetchReq = 1'b0;
    if (loadDone === 1'b1) donePulses++;
    loadData = 32'h2222_2222;
    applyStimulus();
    if (loadDone === 1'b1) donePulses++;
    loadData = 32'h3333_3333;
    loadLast = 1'b1;
    applyStimulus();
    loadValid = 1'b0;
    loadLast  = 1'b0;
    checkOutput("ld4_done_pulse", 64'(loadDone), 64'd1);
    checkOutput("ld4_idle", 64'(fetchReady), 64'd1);
    if (loadDone === 1'b1) donePulses++;
    applyStimulus();
    if (loadDone === 1'b1) donePulses++;
    applyStimulus();
    if (loadDone === 1'b1) donePulses++;
    checkOutput("ld4_done_once", 64'(donePulses), 64'd1);
    doFetch("ld4_a4", 16'd4, 32'h1111_1111, 1'b0);
    applyStimulus();
    checkOutput("hold_valid", 64'(fetchValid), 64'd0);
    checkOutput("hold_data", 64'(fetchData), 64'h1111_1111);
    doFetch("ld4_a5", 16'd5, 32'h2222_2222, 1'b0);
    doFetch("ld4_a6", 16'd6, 32'h3333_3333, 1'b0);
    doFetch("ld4_a3", 16'd3, 32'h0, 1'b0);
    doFetch("ld4_a7", 16'd7, 32'h0, 1'b0);

    // Load from base 2 with stalls.
    loadStart = 1'b1;
    loadBase  = 16'd2;
    applyStimulus();
    loadStart = 1'b0;
    loadValid = 1'b1;
    loadData  = 32'hAAAA_0002;
    applyStimulus();
    loadValid = 1'b0;
    loadData  = 32'hDEAD_BEEF;
    applyStimulus();
    applyStimulus();
    checkOutput("stall_ready", 64'(loadReady), 64'd1);
    loadValid = 1'b1;
    loadData  = 32'hBBBB_0003;
    loadLast  = 1'b1;
    applyStimulus();
    loadValid = 1'b0;
    loadLast  = 1'b0;
    checkOutput("stall_done", 64'(loadDone), 64'd1);
    doFetch("stall_a2", 16'd2, 32'hAAAA_0002, 1'b0);
    doFetch("stall_a3", 16'd3, 32'hBBBB_0003, 1'b0);
    doFetch("stall_a4", 16'd4, 32'h1111_1111, 1'b0);

    // Overflow from base 254.
    donePulses = 0;
    loadStart = 1'b1;
    loadBase  = 16'd254;
    applyStimulus();
    loadStart = 1'b0;
    loadValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      loadData = 32'hC000_0000 + 32'(i);
      applyStimulus();
      if (loadDone === 1'b1) donePulses++;
      if (i == 1) begin
        checkOutput("ovf_err", 64'(loadErr), 64'd1);
        checkOutput("ovf_idle", 64'(fetchReady), 64'd1);
        checkOutput("ovf_load_ready", 64'(loadReady), 64'd0);
      end
    end
    loadValid = 1'b0;
    applyStimulus();
    if (loadDone === 1'b1) donePulses++;
    checkOutput("ovf_no_done", 64'(donePulses), 64'd0);
    checkOutput("ovf_err_sticky", 64'(loadErr), 64'd1);
    doFetch("ovf_a254", 16'd254, 32'hC000_0000, 1'b0);
    doFetch("ovf_a255", 16'd255, 32'hC000_0001, 1'b0);
    doFetch("ovf_a0", 16'd0, 32'h0, 1'b0);

    // Bad base, then a good base clears the flag.
    loadStart = 1'b1;
    loadBase  = 16'd256;
    applyStimulus();
    loadStart = 1'b0;
    checkOutput("badbase_idle", 64'(fetchReady), 64'd1);
    checkOutput("badbase_err", 64'(loadErr), 64'd1);
    loadStart = 1'b1;
    loadBase  = 16'd0;
    applyStimulus();
    loadStart = 1'b0;
    checkOutput("base0_err_clr", 64'(loadErr), 64'd0);
    checkOutput("base0_load", 64'(loadReady), 64'd1);
    loadValid = 1'b1;
    loadData  = 32'h0BAD_0000;
    loadLast  = 1'b1;
    applyStimulus();
    loadValid = 1'b0;
    loadLast  = 1'b0;
    doFetch("base0_a0", 16'd0, 32'h0BAD_0000, 1'b0);

    // Out-of-range fetch and back-to-back fetches.
    doFetch("oor300", 16'd300, 32'h0, 1'b1);
    fetchReq  = 1'b1;
    fetchAddr = 16'd5;
    applyStimulus();
    checkOutput("b2b_5", 64'({fetchValid, fetchErr, fetchData}), {30'd0, 2'b10, 32'h2222_2222});
    fetchAddr = 16'd6;
    applyStimulus();
    checkOutput("b2b_6", 64'({fetchValid, fetchErr, fetchData}), {30'd0, 2'b10, 32'h3333_3333});
    fetchAddr = 16'd5;
    applyStimulus();
    checkOutput("b2b_5b", 64'({fetchValid, fetchErr, fetchData}), {30'd0, 2'b10, 32'h2222_2222});
    fetchReq = 1'b0;

    // Fetch and load start together: fetch sees pre-load contents.
    fetchReq  = 1'b1;
    fetchAddr = 16'd4;
    loadStart = 1'b1;
    loadBase  = 16'd4;
    applyStimulus();
    fetchReq  = 1'b0;
    loadStart = 1'b0;
    checkOutput("both_fetch", 64'({fetchValid, fetchData}), {31'd0, 1'b1, 32'h1111_1111});
    checkOutput("both_load", 64'(loadReady), 64'd1);
    loadValid = 1'b1;
    loadData  = 32'h4444_4444;
    loadLast  = 1'b1;
    applyStimulus();
    loadValid = 1'b0;
    loadLast  = 1'b0;
    doFetch("both_a4", 16'd4, 32'h4444_4444, 1'b0);

    // Reset in the middle of a load, then full re-sweep.
    loadStart = 1'b1;
    loadBase  = 16'd10;
    applyStimulus();
    loadStart = 1'b0;
    loadValid = 1'b1;
    loadData  = 32'h5555_5555;
    applyStimulus();
    loadData  = 32'h6666_6666;
    applyStimulus();
    rstN = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd1);
    checkOutput("midrst_load_ready", 64'(loadReady), 64'd0);
    loadValid = 1'b0;
    applyStimulus();
    rstN = 1'b1;
    measureSweep(sweepCycles);
    checkOutput("resweep_cycles", 64'(sweepCycles), 64'd256);
    fetchReq = 1'b1;
    for (int a = 0; a < 256; a++) begin
      fetchAddr = 16'(a);
      applyStimulus();
      checkOutput("resweep_word", 64'({fetchValid, fetchErr, fetchData}), {30'd0, 2'b10, 32'h0});
    end
    fetchReq = 1'b0;
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
